// File: rtl/counter_sched_pkg.sv
// ---------------------------------------------------------------------------
// counter_sched_pkg
// Shared types and helpers for the shared-counter scheduler.
//   state_t      : scheduler FSM states (IDLE, RUN, DONE)
//   DEF_NUM_REQ  : default number of requesters
//   DEF_CNT_W    : default counter width
//   LEN_BUS_MAX  : widest packed len bus the slice helper accepts
//   len_slice()  : extract the terminal count of one requester from the bus
// Build option: COUNTER_SCHED_PRIO_EN (used by counter_sched_arb).
// ---------------------------------------------------------------------------
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 4;
  localparam int LEN_BUS_MAX = 256;

  // Returns slice idx of a packed len bus, each slice cnt_w bits wide,
  // zero-extended to 32 bits. Callers resize to their own counter width.
  function automatic logic [31:0] len_slice(input logic [LEN_BUS_MAX-1:0] len_bus,
                                            input int idx,
                                            input int cnt_w);
    logic [LEN_BUS_MAX-1:0] shifted;
    logic [31:0]            mask;
    shifted = len_bus >> (idx * cnt_w);
    mask    = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/counter_sched_arb.sv
// ---------------------------------------------------------------------------
// counter_sched_arb
// Picks which requester gets the shared counter next.
// Default build: round-robin. The search starts at the pointer, and the
// pointer moves to the index after the winner whenever a grant is taken.
// With COUNTER_SCHED_PRIO_EN defined: fixed priority, lowest index wins, and
// the pointer register does not exist.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   request levels, one bit per requester
//   update   in   high in the cycle the top registers a grant
//   winner   out  one-hot winner (combinational), 0 when no request
// ---------------------------------------------------------------------------
module counter_sched_arb
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] winner
);

`ifdef COUNTER_SCHED_PRIO_EN

  // No state in this variant, so the clock, reset and update inputs are idle.
  logic unused_prio;
  assign unused_prio = ^{clk, reset_n, update};

  // Walk from the top index down so the lowest set bit is the last to write.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end

`else

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Rotate through the requesters starting at the pointer; the first set
  // request encountered wins.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end

  // The pointer only moves when a grant is actually registered, so a
  // requester that wins is pushed to the back of the next search.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= PTR_W'((int'(win_idx) + 1) % NUM_REQ);
    end
  end

`endif

endmodule

// File: rtl/counter_sched_ctrl.sv
// ---------------------------------------------------------------------------
// counter_sched_ctrl
// Shares one CNT_W-bit up-counter between NUM_REQ requesters. A winner is
// granted, its len slice is latched as the terminal count, and the counter
// runs from 0 while enable is high. Completion or an early request drop is
// reported with a one-cycle done/abort pulse on the owner's bit.
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   req          in   request levels, held until done/abort
//   len          in   packed terminal counts, slice i = len[i*CNT_W +: CNT_W]
//   enable       in   global count enable, low stalls the running job
//   grant        out  one-hot owner of the counter, 0 when idle
//   busy         out  high in RUN and DONE
//   counter_out  out  current count of the running job
//   done         out  one-cycle completion pulse, bit = owner
//   abort        out  one-cycle abort pulse, bit = owner
// Build option: COUNTER_SCHED_PRIO_EN selects fixed-priority arbitration.
// ---------------------------------------------------------------------------
module counter_sched_ctrl
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  input  logic                     enable,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [CNT_W-1:0]         counter_out,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       abort
);

  state_t             state;
  logic [NUM_REQ-1:0] winner;
  logic [CNT_W-1:0]   terminal;
  logic [CNT_W-1:0]   sel_len;
  logic               start;

  assign start = (state == IDLE) && (|req);

  counter_sched_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .update  (start),
    .winner  (winner)
  );

  // Terminal count of whichever requester is about to be granted.
  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        sel_len = CNT_W'(len_slice(LEN_BUS_MAX'(len), i, CNT_W));
      end
    end
  end

  // Scheduler FSM. The terminal is latched at grant so later len changes do
  // not affect the running job. In RUN, reaching the terminal is checked
  // before the request drop so completion wins a same-cycle tie, and the
  // counter is never incremented past the terminal (no wrap at all-ones).
  // DONE is a one-cycle cleanup that clears the pulses and the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      counter_out <= '0;
      done        <= '0;
      abort       <= '0;
      terminal    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done  <= '0;
          abort <= '0;
          if (start) begin
            grant       <= winner;
            terminal    <= sel_len;
            counter_out <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (enable && (counter_out == terminal)) begin
            done  <= grant;
            grant <= '0;
            state <= DONE;
          end else if ((req & grant) == '0) begin
            abort <= grant;
            grant <= '0;
            state <= DONE;
          end else if (enable) begin
            counter_out <= counter_out + CNT_W'(1);
          end
        end
        DONE: begin
          done        <= '0;
          abort       <= '0;
          counter_out <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_sched_ctrl
// Directed bench for counter_sched_ctrl (NUM_REQ=4, CNT_W=4). Stimulus pushes
// expected grant/done/abort events (value, cycle, count) into a queue; a
// monitor pops and compares whenever the DUT shows one of those events.
// Honours COUNTER_SCHED_PRIO_EN for the expected grant order.
// ---------------------------------------------------------------------------
module tb_counter_sched_ctrl;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;

  typedef struct {
    int         kind;
    logic [3:0] val;
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic                     enable;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         counter_out;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       abort;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  logic [NUM_REQ-1:0] prev_grant = '0;

  counter_sched_ctrl #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .len         (len),
    .enable      (enable),
    .grant       (grant),
    .busy        (busy),
    .counter_out (counter_out),
    .done        (done),
    .abort       (abort)
  );

  // Free-running clock and a cycle counter stepped on every rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input int kind);
    case (kind)
      EV_GRANT: return "grant";
      EV_DONE:  return "done";
      default:  return "abort";
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic e);
    req    = r;
    enable = e;
  endtask

  task automatic pushExp(input int kind, input logic [3:0] val, input int c, input logic [3:0] cnt);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, actual, expected);
    end
  endtask

  // Compares one observed event against the head of the expectation queue.
  task automatic checkEvent(input int kind, input logic [3:0] val);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_%s: got val=%b cyc=%0d cnt=%0d, required no event",
               kindName(kind), val, cyc, counter_out);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc || e.cnt !== counter_out) begin
        errors++;
        $display("[TB] FAIL event: got %s val=%b cyc=%0d cnt=%0d, required %s val=%b cyc=%0d cnt=%0d",
                 kindName(kind), val, cyc, counter_out, kindName(e.kind), e.val, e.cyc, e.cnt);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (grant != '0 && prev_grant == '0) checkEvent(EV_GRANT, grant);
    if (done != '0) checkEvent(EV_DONE, done);
    if (abort != '0) checkEvent(EV_ABORT, abort);
    prev_grant <= grant;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int         c;
    int         r;
    logic [3:0] g;

    reset_n = 1'b0;
    len     = '0;
    applyStimulus(4'b0000, 1'b0);
    tick(3);
    checkOutput("reset_state", 32'({grant, busy, counter_out, done, abort}), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("idle", 32'({grant, busy, counter_out, done, abort}), 32'd0);
    end

    // Single job on requester 1, terminal 5.
    c   = cyc;
    len = 16'h0050;
    applyStimulus(4'b0010, 1'b1);
    pushExp(EV_GRANT, 4'b0010, c + 1, 4'd0);
    pushExp(EV_DONE,  4'b0010, c + 7, 4'd5);
    for (int n = 0; n <= 5; n++) begin
      tick(1);
      checkOutput("single_count", 32'(counter_out), 32'(n));
      checkOutput("single_busy", 32'(busy), 32'd1);
    end
    tick(1);
    applyStimulus(4'b0000, 1'b1);
    tick(1);
    checkOutput("single_after", 32'({grant, busy, counter_out}), 32'd0);

    // Reset again so the round-robin pointer starts at 0.
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Round robin: all four requesting, terminal 2 each.
    c   = cyc;
    len = 16'h2222;
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
`ifdef COUNTER_SCHED_PRIO_EN
      g = 4'b0001;
`else
      g = 4'b0001 << (i % 4);
`endif
      pushExp(EV_GRANT, g, c + 1 + 5 * i, 4'd0);
      pushExp(EV_DONE,  g, c + 4 + 5 * i, 4'd2);
    end
    tick(24);
    applyStimulus(4'b0000, 1'b1);
    tick(2);

    // Terminal 0 with enable low at first: done waits for an enabled cycle.
    c   = cyc;
    len = 16'h0000;
    applyStimulus(4'b0001, 1'b0);
    pushExp(EV_GRANT, 4'b0001, c + 1, 4'd0);
    pushExp(EV_DONE,  4'b0001, c + 4, 4'd0);
    tick(3);
    checkOutput("len0_stalled", 32'({busy, grant}), 32'b10001);
    applyStimulus(4'b0001, 1'b1);
    tick(1);
    applyStimulus(4'b0000, 1'b1);
    tick(2);

    // Terminal 15 with enable toggling every cycle: stops at 15, no wrap.
    c   = cyc;
    len = 16'h0F00;
    applyStimulus(4'b0100, 1'b1);
    pushExp(EV_GRANT, 4'b0100, c + 1, 4'd0);
    pushExp(EV_DONE,  4'b0100, c + 32, 4'd15);
    tick(1);
    for (int j = 0; j <= 30; j++) begin
      enable = ~j[0];
      tick(1);
      if (j == 1)  checkOutput("stall_hold", 32'(counter_out), 32'd1);
      if (j == 29) checkOutput("max_hold", 32'(counter_out), 32'd15);
    end
    applyStimulus(4'b0000, 1'b1);
    tick(2);

    // Abort: requester 2 drops at count 3 of 7.
    c   = cyc;
    len = 16'h0700;
    applyStimulus(4'b0100, 1'b1);
    pushExp(EV_GRANT, 4'b0100, c + 1, 4'd0);
    pushExp(EV_ABORT, 4'b0100, c + 5, 4'd3);
    tick(4);
    applyStimulus(4'b0000, 1'b1);
    tick(2);
    checkOutput("abort_after", 32'({grant, busy, counter_out}), 32'd0);

    // Drop coinciding with the terminal: completion wins.
    c   = cyc;
    len = 16'h0300;
    applyStimulus(4'b0100, 1'b1);
    pushExp(EV_GRANT, 4'b0100, c + 1, 4'd0);
    pushExp(EV_DONE,  4'b0100, c + 5, 4'd3);
    tick(4);
    applyStimulus(4'b0000, 1'b1);
    tick(2);

    // len change mid-run is ignored: still completes at 9.
    c   = cyc;
    len = 16'h0009;
    applyStimulus(4'b0001, 1'b1);
    pushExp(EV_GRANT, 4'b0001, c + 1, 4'd0);
    pushExp(EV_DONE,  4'b0001, c + 11, 4'd9);
    tick(5);
    checkOutput("lenchg_count", 32'(counter_out), 32'd4);
    len = 16'h0002;
    tick(6);
    applyStimulus(4'b0000, 1'b1);
    tick(2);

    // Reset mid-run clears at once; held request is granted right after release.
    c   = cyc;
    len = 16'h00A0;
    applyStimulus(4'b0010, 1'b1);
    pushExp(EV_GRANT, 4'b0010, c + 1, 4'd0);
    tick(4);
    checkOutput("pre_reset_count", 32'(counter_out), 32'd3);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_midrun", 32'({grant, busy, counter_out, done, abort}), 32'd0);
    tick(2);
    len     = 16'h0010;
    r       = cyc;
    reset_n = 1'b1;
    pushExp(EV_GRANT, 4'b0010, r + 1, 4'd0);
    pushExp(EV_DONE,  4'b0010, r + 3, 4'd1);
    tick(3);
    applyStimulus(4'b0000, 1'b1);
    tick(4);
    checkOutput("final_idle", 32'({grant, busy, counter_out, done, abort}), 32'd0);

    checkOutput("events_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
